// File: rtl/clock_bcd_converter.sv
// Iterative double-dabble converter from binary h/m/s to six BCD digits for the display stage.
// Optional build macro: TWELVE_HOUR_EN (12-hour display with PM flag).
module clock_bcd_converter #(
    parameter int unsigned FIELD_W    = 6,
    parameter int unsigned HOUR_MAX   = 23,
    parameter int unsigned MINSEC_MAX = 59
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_stb,
    input  logic [4:0]         i_hours,
    input  logic [FIELD_W-1:0] i_minutes,
    input  logic [FIELD_W-1:0] i_seconds,
    output logic               o_busy,
    output logic               o_write_stb,
    output logic               o_range_err,
    output logic               o_pm,
    output logic [3:0]         o_hours_msb,
    output logic [3:0]         o_hours_lsb,
    output logic [3:0]         o_minutes_msb,
    output logic [3:0]         o_minutes_lsb,
    output logic [3:0]         o_seconds_msb,
    output logic [3:0]         o_seconds_lsb
);

    localparam int unsigned BCD_W = 8;
    localparam int unsigned SR_W  = BCD_W + FIELD_W;
    localparam int unsigned CNT_W = $clog2(FIELD_W + 1);
    localparam int unsigned DIG_W = 3 * BCD_W;

    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SR_W-1:0]    sr_h_q, sr_h_d, sr_m_q, sr_m_d, sr_s_q, sr_s_d;
    logic [DIG_W-1:0]   digits_q, digits_d;
    logic               busy_q, busy_d;
    logic               wstb_q, wstb_d;
    logic               rerr_q, rerr_d;
    logic               pm_q, pm_d;
    logic               pm_pend_q, pm_pend_d;

    logic [FIELD_W-1:0] hours_ext, hours_clamped, hours_disp;
    logic [FIELD_W-1:0] minutes_clamped, seconds_clamped;
    logic               hours_oor, minutes_oor, seconds_oor;
    logic               pm_c;

    function automatic logic [FIELD_W-1:0] clamp(input logic [FIELD_W-1:0] v,
                                                 input logic [FIELD_W-1:0] max_v);
        return (v > max_v) ? max_v : v;
    endfunction

    // One double-dabble step: correct each BCD nibble, then shift {bcd,bin} left.
    function automatic logic [SR_W-1:0] dabble(input logic [SR_W-1:0] v);
        logic [SR_W-1:0] t;
        t = v;
        for (int i = 0; i < int'(BCD_W / 4); i++) begin
            if (t[FIELD_W + 4*i +: 4] >= 4'd5)
                t[FIELD_W + 4*i +: 4] = t[FIELD_W + 4*i +: 4] + 4'd3;
        end
        return {t[SR_W-2:0], 1'b0};
    endfunction

    assign hours_ext       = FIELD_W'(i_hours);
    assign hours_oor       = hours_ext > FIELD_W'(HOUR_MAX);
    assign minutes_oor     = i_minutes > FIELD_W'(MINSEC_MAX);
    assign seconds_oor     = i_seconds > FIELD_W'(MINSEC_MAX);
    assign hours_clamped   = clamp(hours_ext, FIELD_W'(HOUR_MAX));
    assign minutes_clamped = clamp(i_minutes, FIELD_W'(MINSEC_MAX));
    assign seconds_clamped = clamp(i_seconds, FIELD_W'(MINSEC_MAX));

`ifdef TWELVE_HOUR_EN
    assign pm_c       = hours_clamped >= FIELD_W'(12);
    assign hours_disp = (hours_clamped == '0)          ? FIELD_W'(12) :
                        (hours_clamped > FIELD_W'(12)) ? hours_clamped - FIELD_W'(12) :
                                                         hours_clamped;
`else
    assign pm_c       = 1'b0;
    assign hours_disp = hours_clamped;
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sr_h_q    <= '0;
            sr_m_q    <= '0;
            sr_s_q    <= '0;
            digits_q  <= '0;
            busy_q    <= 1'b0;
            wstb_q    <= 1'b0;
            rerr_q    <= 1'b0;
            pm_q      <= 1'b0;
            pm_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sr_h_q    <= sr_h_d;
            sr_m_q    <= sr_m_d;
            sr_s_q    <= sr_s_d;
            digits_q  <= digits_d;
            busy_q    <= busy_d;
            wstb_q    <= wstb_d;
            rerr_q    <= rerr_d;
            pm_q      <= pm_d;
            pm_pend_q <= pm_pend_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_h_d    = sr_h_q;
        sr_m_d    = sr_m_q;
        sr_s_d    = sr_s_q;
        digits_d  = digits_q;
        busy_d    = busy_q;
        wstb_d    = 1'b0;
        rerr_d    = rerr_q;
        pm_d      = pm_q;
        pm_pend_d = pm_pend_q;
        case (state_q)
            IDLE: begin
                if (i_stb) begin
                    sr_h_d    = {BCD_W'(0), hours_disp};
                    sr_m_d    = {BCD_W'(0), minutes_clamped};
                    sr_s_d    = {BCD_W'(0), seconds_clamped};
                    rerr_d    = hours_oor | minutes_oor | seconds_oor;
                    pm_pend_d = pm_c;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = CONVERT;
                end
            end
            CONVERT: begin
                sr_h_d = dabble(sr_h_q);
                sr_m_d = dabble(sr_m_q);
                sr_s_d = dabble(sr_s_q);
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(FIELD_W - 1))
                    state_d = DONE;
            end
            DONE: begin
                digits_d = {sr_h_q[SR_W-1 -: BCD_W], sr_m_q[SR_W-1 -: BCD_W],
                            sr_s_q[SR_W-1 -: BCD_W]};
                pm_d     = pm_pend_q;
                wstb_d   = 1'b1;
                busy_d   = 1'b0;
                cnt_d    = '0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_busy        = busy_q;
    assign o_write_stb   = wstb_q;
    assign o_range_err   = rerr_q;
    assign o_pm          = pm_q;
    assign o_hours_msb   = digits_q[23:20];
    assign o_hours_lsb   = digits_q[19:16];
    assign o_minutes_msb = digits_q[15:12];
    assign o_minutes_lsb = digits_q[11:8];
    assign o_seconds_msb = digits_q[7:4];
    assign o_seconds_lsb = digits_q[3:0];

endmodule
